// File: rtl/zxuno_regbus_if.sv
// rtl/zxuno_regbus_if.sv - ZXUNO register bus signal bundle
//
// Groups the CPU I/O cycle, device read-back and register strobe signals.
//   slave  : seen by zxuno_regbus_ctrl (takes CPU + device inputs, drives strobes/read data)
//   master : seen by the CPU side / environment driving the cycles
// Signals:
//   a[15:0], iorq_n, rd_n, wr_n, din[7:0]   CPU I/O cycle
//   dev_dout[8*NDEV-1:0], dev_oe[NDEV-1:0]  device read data and output enables
//   zxuno_addr, zxuno_regrd, zxuno_regwr,
//   regaddr_changed, wrdata                 register strobes to devices
//   dout, oe, collide                       arbitrated CPU read byte and status
interface zxuno_regbus_if #(
  parameter int NDEV = 8
);
  logic [15:0]         a;
  logic                iorq_n;
  logic                rd_n;
  logic                wr_n;
  logic [7:0]          din;
  logic [8*NDEV-1:0]   dev_dout;
  logic [NDEV-1:0]     dev_oe;
  logic [7:0]          zxuno_addr;
  logic                zxuno_regrd;
  logic                zxuno_regwr;
  logic                regaddr_changed;
  logic [7:0]          wrdata;
  logic [7:0]          dout;
  logic                oe;
  logic                collide;

  modport slave (
    input  a, iorq_n, rd_n, wr_n, din, dev_dout, dev_oe,
    output zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, wrdata,
           dout, oe, collide
  );

  modport master (
    output a, iorq_n, rd_n, wr_n, din, dev_dout, dev_oe,
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, wrdata,
           dout, oe, collide
  );
endinterface

// File: rtl/zxuno_regbus_ctrl.sv
// rtl/zxuno_regbus_ctrl.sv - ZXUNO register bus controller (port decode, strobes, read arbitration)
//
// Decodes CPU I/O cycles on the register-select port (ADDR_PORT) and the
// register-data port (DATA_PORT), holds the selected register number, issues
// write/read strobes to the register devices and arbitrates their read data.
// Ports:
//   clk    system clock, all CPU signals synchronous to it
//   rst_n  synchronous active-low reset
//   bus    zxuno_regbus_if.slave (CPU cycle, device read-back, strobes, dout/oe/collide)
// Optional feature macro: ZXUNO_OECOLLIDE_EN enables sticky detection of more
// than one device driving during a data-port read; otherwise collide is 0.
module zxuno_regbus_ctrl #(
  parameter int          NDEV      = 8,
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input logic            clk,
  input logic            rst_n,
  zxuno_regbus_if.slave  bus
);

  logic       io_rd;
  logic       io_wr;
  logic       sel_a;
  logic       sel_d;
  logic       wr_edge;
  logic       prev_wr;
  logic [7:0] win_data;

  logic [7:0] addr_q;
  logic [7:0] wrdata_q;
  logic [7:0] dout_q;
  logic       oe_q;
  logic       regrd_q;
  logic       regwr_q;
  logic       addr_chg_q;
  logic       collide_q;

  assign io_rd   = !bus.iorq_n && !bus.rd_n;
  assign io_wr   = !bus.iorq_n && !bus.wr_n;
  assign sel_a   = (bus.a == ADDR_PORT);
  assign sel_d   = (bus.a == DATA_PORT);
  // prev_wr follows io_wr regardless of address, so retargeting the address
  // mid-cycle never produces a second event for the same CPU write.
  assign wr_edge = io_wr && !prev_wr;

  // Fixed priority: scan from the top so the lowest enabled index is the
  // last assignment and wins. FFh when nobody drives.
  always_comb begin
    win_data = 8'hFF;
    for (int k = NDEV - 1; k >= 0; k--) begin
      if (bus.dev_oe[k]) begin
        win_data = bus.dev_dout[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_wr    <= 1'b0;
      addr_q     <= 8'h00;
      wrdata_q   <= 8'h00;
      dout_q     <= 8'hFF;
      oe_q       <= 1'b0;
      regrd_q    <= 1'b0;
      regwr_q    <= 1'b0;
      addr_chg_q <= 1'b0;
    end else begin
      prev_wr    <= io_wr;
      // Pulses even when the value is unchanged: devices rewind on it.
      addr_chg_q <= wr_edge && sel_a;
      regwr_q    <= wr_edge && sel_d;
      regrd_q    <= io_rd && sel_d;
      if (wr_edge && sel_a) begin
        addr_q <= bus.din;
      end
      if (wr_edge && sel_d) begin
        wrdata_q <= bus.din;
      end
      if (io_rd && sel_a) begin
        dout_q <= addr_q;
        oe_q   <= 1'b1;
      end else if (io_rd && sel_d) begin
        dout_q <= win_data;
        oe_q   <= 1'b1;
      end else begin
        dout_q <= 8'hFF;
        oe_q   <= 1'b0;
      end
    end
  end

`ifdef ZXUNO_OECOLLIDE_EN
  logic [NDEV-1:0] oe_rest;
  logic            multi_oe;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign oe_rest  = bus.dev_oe & (bus.dev_oe - NDEV'(1));
  assign multi_oe = |oe_rest;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collide_q <= 1'b0;
    end else if (wr_edge && sel_a) begin
      collide_q <= 1'b0;
    end else if (io_rd && sel_d && multi_oe) begin
      collide_q <= 1'b1;
    end
  end
`else
  assign collide_q = 1'b0;
`endif

  assign bus.zxuno_addr      = addr_q;
  assign bus.wrdata          = wrdata_q;
  assign bus.dout            = dout_q;
  assign bus.oe              = oe_q;
  assign bus.zxuno_regrd     = regrd_q;
  assign bus.zxuno_regwr     = regwr_q;
  assign bus.regaddr_changed = addr_chg_q;
  assign bus.collide         = collide_q;

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// tb/tb_zxuno_regbus_ctrl.sv - scoreboard bench for zxuno_regbus_ctrl
module tb_zxuno_regbus_ctrl;
  localparam int          NDEV = 8;
  localparam logic [15:0] AP   = 16'hFC3B;
  localparam logic [15:0] DP   = 16'hFD3B;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  zxuno_regbus_if #(.NDEV(NDEV)) bus ();

  zxuno_regbus_ctrl #(.NDEV(NDEV), .ADDR_PORT(AP), .DATA_PORT(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  int         addr_pulses = 0;
  int         wr_pulses   = 0;
  logic       oe_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: pop an expectation whenever the DUT produces an event.
  always @(negedge clk) begin
    if (bus.regaddr_changed) begin
      addr_pulses++;
      if (exp_addr_q.size() == 0) check("addr_spurious", 1, 0);
      else check("zxuno_addr", bus.zxuno_addr, exp_addr_q.pop_front());
    end
    if (bus.zxuno_regwr) begin
      wr_pulses++;
      if (exp_wr_q.size() == 0) check("wr_spurious", 1, 0);
      else check("wrdata", bus.wrdata, exp_wr_q.pop_front());
    end
    if (bus.oe && !oe_d) begin
      if (exp_rd_q.size() == 0) check("rd_spurious", 1, 0);
      else check("dout", bus.dout, exp_rd_q.pop_front());
    end
    oe_d = bus.oe;
  end

  task automatic idle();
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input int n);
    int a0, w0;
    a0 = addr_pulses;
    w0 = wr_pulses;
    @(posedge clk); #1;
    bus.a = addr; bus.din = data; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    if (addr == AP) exp_addr_q.push_back(data);
    else exp_wr_q.push_back(data);
    repeat (n) @(posedge clk);
    #1 idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("addr_pulse_cnt", addr_pulses - a0, (addr == AP) ? 1 : 0);
    check("wr_pulse_cnt", wr_pulses - w0, (addr == DP) ? 1 : 0);
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic [7:0] exp, input int n);
    @(posedge clk); #1;
    bus.a = addr; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    exp_rd_q.push_back(exp);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("regrd_level", bus.zxuno_regrd, (addr == DP) ? 1 : 0);
      check("oe_level", bus.oe, 1);
    end
    idle();
    @(negedge clk);
    check("regrd_fall", bus.zxuno_regrd, 0);
    check("oe_fall", bus.oe, 0);
    check("dout_idle", bus.dout, 8'hFF);
  endtask

  function automatic logic [7:0] model_winner(input logic [NDEV-1:0] oe_v,
                                              input logic [8*NDEV-1:0] d_v);
    int k;
    k = 0;
    while (k < NDEV && !oe_v[k]) k++;
    if (k == NDEV) return 8'hFF;
    return d_v[8*k +: 8];
  endfunction

  logic [NDEV-1:0] pat;
  logic            exp_col;
  int              a0;

  initial begin
    rst_n = 1'b0;
    bus.a = 16'h0000; bus.din = 8'h00;
    bus.dev_dout = '0; bus.dev_oe = '0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", bus.zxuno_addr, 8'h00);
    check("rst_wrdata", bus.wrdata, 8'h00);
    check("rst_dout", bus.dout, 8'hFF);
    check("rst_oe", bus.oe, 0);
    check("rst_regrd", bus.zxuno_regrd, 0);
    check("rst_regwr", bus.zxuno_regwr, 0);
    check("rst_achg", bus.regaddr_changed, 0);
    check("rst_collide", bus.collide, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    cpu_write(AP, 8'hFF, 4);
    cpu_write(AP, 8'hFF, 4);
    cpu_write(DP, 8'h5A, 6);

    bus.dev_dout[16 +: 8] = 8'h41;
    bus.dev_oe = 8'b0000_0100;
    cpu_read(DP, 8'h41, 3);

    bus.dev_oe = '0;
    cpu_read(DP, 8'hFF, 3);

    cpu_write(AP, 8'h37, 2);
    bus.dev_dout[7:0] = 8'h11;
    bus.dev_oe = 8'b0000_0001;
    cpu_read(AP, 8'h37, 3);

    bus.dev_dout[8 +: 8] = 8'h22;
    bus.dev_oe = 8'b0000_0110;
    cpu_read(DP, 8'h22, 2);
`ifdef ZXUNO_OECOLLIDE_EN
    exp_col = 1'b1;
`else
    exp_col = 1'b0;
`endif
    check("collide_set", bus.collide, exp_col);
    cpu_write(AP, 8'h10, 1);
    check("collide_clr", bus.collide, 0);

    for (int i = 0; i < NDEV; i++) bus.dev_dout[8*i +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 6; i++) begin
      pat = NDEV'($urandom_range(0, 255));
      bus.dev_oe = pat;
      cpu_read(DP, model_winner(pat, bus.dev_dout), 1 + i % 3);
    end
    bus.dev_oe = '0;

    // Retarget the address mid-write: only the original edge counts.
    a0 = addr_pulses;
    @(posedge clk); #1;
    bus.a = AP; bus.din = 8'h55; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    exp_addr_q.push_back(8'h55);
    @(posedge clk); #1 bus.a = DP;
    repeat (3) @(posedge clk);
    #1 idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("retarget_pulses", addr_pulses - a0, 1);
    check("retarget_wrdata", bus.wrdata, 8'h5A);

    // Reset in the middle of a data-port read.
    bus.dev_dout[24 +: 8] = 8'h99;
    bus.dev_oe = 8'b0000_1000;
    @(posedge clk); #1;
    bus.a = DP; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    exp_rd_q.push_back(8'h99);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_oe", bus.oe, 0);
    check("midrst_dout", bus.dout, 8'hFF);
    check("midrst_addr", bus.zxuno_addr, 8'h00);
    check("midrst_regrd", bus.zxuno_regrd, 0);
    idle();
    bus.dev_oe = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Write still active across reset release yields a second strobe.
    a0 = addr_pulses;
    @(posedge clk); #1;
    bus.a = AP; bus.din = 8'h6C; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    exp_addr_q.push_back(8'h6C);
    exp_addr_q.push_back(8'h6C);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstrel_pulses", addr_pulses - a0, 2);
    check("rstrel_addr", bus.zxuno_addr, 8'h6C);

    check("sb_addr_empty", exp_addr_q.size(), 0);
    check("sb_wr_empty", exp_wr_q.size(), 0);
    check("sb_rd_empty", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/zxuno_regbus_ctrl.md
# zxuno_regbus_ctrl

Controller for the ZXUNO register bus. It decodes CPU I/O cycles on the address port (FC3Bh) and the data port (FD3Bh), and holds the selected register number. It issues per-register read and write strobes and the address-change pulse to every register device. It also arbitrates the read data returned by up to NDEV devices into the single byte driven back onto the CPU data bus. It sits between the CPU I/O decode and all register peripherals, such as the core-ID string reader and the config registers.

## Interface
- NDEV, 8: number of register devices on the read bus (1..16).
- ADDR_PORT, 16'hFC3B: I/O address of the register-select port.
- DATA_PORT, 16'hFD3B: I/O address of the register-data port.

- clk  in  1  system clock. All CPU signals are synchronous to it.
- rst_n  in  1  reset. Synchronous, active-low.
- a  in  16  CPU address bus.
- iorq_n  in  1  CPU I/O request, active-low.
- rd_n  in  1  CPU read, active-low.
- wr_n  in  1  CPU write, active-low.
- din  in  8  CPU write data.
- dev_dout  in  8*NDEV  packed device read data; device k occupies bits [8k+7:8k].
- dev_oe  in  NDEV  device output enables.
- zxuno_addr  out  8  currently selected register number.
- zxuno_regrd  out  1  level; high while a data-port read cycle is in progress.
- zxuno_regwr  out  1  one-cycle pulse per data-port write cycle.
- regaddr_changed  out  1  one-cycle pulse per address-port write.
- wrdata  out  8  byte latched from the data-port write, valid with zxuno_regwr.
- dout  out  8  arbitrated read byte for the CPU.
- oe  out  1  high when dout must be driven onto the CPU bus.
- collide  out  1  sticky multi-driver flag (see Configuration).

## Operation
- Cycle decode, registered each clk:
  - io_rd = !iorq_n & !rd_n.
  - io_wr = !iorq_n & !wr_n.
  - sel_a = (a==ADDR_PORT).
  - sel_d = (a==DATA_PORT).
- Write strobes use a rising-edge detector on io_wr (prev_wr register), so exactly one event occurs per CPU write cycle regardless of its length in clk cycles.
- Address-port write (edge): zxuno_addr <= din and regaddr_changed pulses for 1 cycle. This happens even when the new value equals the old value, because devices rely on it to rewind internal indices.
- Data-port write (edge): wrdata <= din and zxuno_regwr pulses for 1 cycle.
- Data-port read:
  - zxuno_regrd = registered (io_rd & sel_d).
  - It stays high for the whole cycle and drops the cycle after rd_n/iorq_n deassert.
  - Devices advance auto-increment state on its falling edge.
- Address-port read: the block itself sources dout = zxuno_addr with oe = 1. Devices are ignored.
- Arbitration during data-port reads:
  - Fixed priority, lowest index k with dev_oe[k]=1 wins.
  - dout <= winner's byte and oe <= 1.
- Data-port read with no dev_oe high: dout <= 8'hFF and oe <= 1, so unimplemented registers read FFh.
- Outside read cycles: oe <= 0 and dout <= 8'hFF.
- Simultaneous address-port write and device activity: devices see zxuno_addr and regaddr_changed in the same cycle.

## Timing
- Reset values:
  - zxuno_addr = 8'h00, wrdata = 8'h00, dout = 8'hFF.
  - zxuno_regrd, zxuno_regwr, regaddr_changed, oe and collide are all 0.
  - prev_wr = 0.
- Latency:
  - Strobes appear 1 clk after the first cycle in which iorq_n/wr_n (or rd_n) are both low with a matching address.
  - Read data: dout/oe are valid 1 clk after the dev_oe/dev_dout they reflect.
- Reset asserted mid-cycle:
  - All outputs return to reset values on the next edge.
  - prev_wr clears, so a write cycle still active when rst_n releases produces one strobe on the following edge.
- An address change during an active io cycle (a different port) ends the decode the next clk. No strobe is generated for a write that was already edge-detected.

## Configuration
- ZXUNO_OECOLLIDE_EN defined:
  - During a data-port read, if two or more dev_oe bits are high in the same cycle, collide <= 1 (sticky).
  - Any address-port write clears it (clear takes priority over a same-cycle set).
  - Arbitration result is unchanged.
- Not defined: collide is constant 0 and no detection logic is built.

## Test plan
- Reset, then write 8'hFF to FC3Bh over a 4-clk CPU cycle → zxuno_addr=FFh and exactly one regaddr_changed pulse. Repeat the same value → a second pulse.
- Write 5Ah to FD3Bh over a 6-clk cycle → wrdata=5Ah and exactly one 1-clk zxuno_regwr pulse.
- Data-port read with dev_oe=8'b0000_0100 and device 2 data 41h → dout=41h and oe=1 one clk later. zxuno_regrd stays high for the full cycle and falls 1 clk after rd_n rises.
- Data-port read with dev_oe=0 → dout=FFh, oe=1. Read FC3Bh after selecting 37h → dout=37h.
- With ZXUNO_OECOLLIDE_EN: dev_oe=8'b0000_0110 → dout=device 1 data and collide=1. A subsequent FC3Bh write → collide=0.
- Assert rst_n=0 mid data-port read → next edge oe=0, dout=FFh, zxuno_addr=00h.
